// File: rtl/menu_ctrl.sv
// Menu/screen controller: button edges are latched per frame and applied one at a time on refr_tick.
// Optional highlight blink is enabled by defining HILITE_BLINK_EN.
module menu_ctrl #(
  parameter int NUM_SQ       = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_sel,
  input  logic       btn_back,
  output logic [1:0] screen,
  output logic [2:0] sel_idx,
  output logic       hilite_on,
  output logic       note_req,
  output logic [2:0] note_idx
);

  typedef enum logic [1:0] {
    SCR_MENU   = 2'd0,
    SCR_PLAY   = 2'd1,
    SCR_LISTEN = 2'd2,
    SCR_DIR    = 2'd3
  } screen_e;

  localparam logic [2:0] SQ_MAX   = 3'(NUM_SQ - 1);
  localparam logic [2:0] MENU_MAX = 3'd2;

  screen_e    screen_q, screen_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] ret_q, ret_d;
  logic [2:0] note_idx_q, note_idx_d;
  logic       note_req_q, note_req_d;
  logic       hilite_q, hilite_d;
  logic [3:0] btn_prev_q;
  logic       armed_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] btn_lvl, edge_det, pend_all;
  logic [2:0] item_max;
  logic       nav_screen;

`ifdef HILITE_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       applied;
`endif

  // Bit order: 0=l, 1=r, 2=sel, 3=back (priority rises with index).
  assign btn_lvl = {btn_back, btn_sel, btn_r, btn_l};

  always_comb begin
    edge_det   = armed_q ? (btn_lvl & ~btn_prev_q) : 4'b0000;
    pend_all   = pend_q | edge_det;
    nav_screen = (screen_q == SCR_MENU) || (screen_q == SCR_PLAY);
    item_max   = (screen_q == SCR_PLAY) ? SQ_MAX : MENU_MAX;
    pend_d     = refr_tick ? 4'b0000 : pend_all;
    screen_d   = screen_q;
    sel_d      = sel_q;
    ret_d      = ret_q;
    note_idx_d = note_idx_q;
    note_req_d = 1'b0;
    hilite_d   = hilite_q;
`ifdef HILITE_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    applied     = 1'b0;
`endif
    if (refr_tick) begin
      if (pend_all[3]) begin
        if (screen_q != SCR_MENU) begin
          screen_d = SCR_MENU;
          sel_d    = {1'b0, ret_q};
        end
      end else if (pend_all[2]) begin
        if (screen_q == SCR_MENU) begin
          screen_d = screen_e'(sel_q[1:0] + 2'd1);
          sel_d    = 3'd0;
          ret_d    = sel_q[1:0];
        end else if (screen_q == SCR_PLAY) begin
          note_idx_d = sel_q;
          note_req_d = 1'b1;
        end
      end else if (pend_all[1]) begin
        if (nav_screen) sel_d = (sel_q >= item_max) ? 3'd0 : sel_q + 3'd1;
      end else if (pend_all[0]) begin
        if (nav_screen) sel_d = (sel_q == 3'd0 || sel_q > item_max) ? item_max : sel_q - 3'd1;
      end

`ifdef HILITE_BLINK_EN
      // Every acting event changes screen, sel_idx, or fires a note.
      applied = (screen_d != screen_q) || (sel_d != sel_q) || note_req_d;
      if (screen_d == SCR_LISTEN || screen_d == SCR_DIR) begin
        hilite_d    = 1'b0;
        blink_cnt_d = 8'd0;
      end else if (applied) begin
        hilite_d    = 1'b1;
        blink_cnt_d = 8'd0;
      end else if (blink_cnt_q >= 8'(BLINK_FRAMES - 1)) begin
        hilite_d    = ~hilite_q;
        blink_cnt_d = 8'd0;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
`else
      hilite_d = (screen_d == SCR_MENU) || (screen_d == SCR_PLAY);
`endif
    end
  end

  // armed_q suppresses a spurious edge from a button held through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      screen_q   <= SCR_MENU;
      sel_q      <= 3'd0;
      ret_q      <= 2'd0;
      note_idx_q <= 3'd0;
      note_req_q <= 1'b0;
      hilite_q   <= 1'b1;
      btn_prev_q <= 4'b0000;
      armed_q    <= 1'b0;
      pend_q     <= 4'b0000;
    end else begin
      screen_q   <= screen_d;
      sel_q      <= sel_d;
      ret_q      <= ret_d;
      note_idx_q <= note_idx_d;
      note_req_q <= note_req_d;
      hilite_q   <= hilite_d;
      btn_prev_q <= btn_lvl;
      armed_q    <= 1'b1;
      pend_q     <= pend_d;
    end
  end

`ifdef HILITE_BLINK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) blink_cnt_q <= 8'd0;
    else        blink_cnt_q <= blink_cnt_d;
  end
`endif

  assign screen    = screen_q;
  assign sel_idx   = sel_q;
  assign hilite_on = hilite_q;
  assign note_req  = note_req_q;
  assign note_idx  = note_idx_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl; blink scenario runs only when HILITE_BLINK_EN is defined.
module tb_menu_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refr_tick = 1'b0;
  logic [3:0] btns = 4'b0000;  // 0=l 1=r 2=sel 3=back
  logic [1:0] screen;
  logic [2:0] sel_idx;
  logic       hilite_on;
  logic       note_req;
  logic [2:0] note_idx;
  int         checks = 0;
  int         failures = 0;

  menu_ctrl #(.NUM_SQ(8), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .refr_tick(refr_tick),
    .btn_l(btns[0]), .btn_r(btns[1]), .btn_sel(btns[2]), .btn_back(btns[3]),
    .screen(screen), .sel_idx(sel_idx), .hilite_on(hilite_on),
    .note_req(note_req), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    refr_tick = 1'b1;
    cyc();
    refr_tick = 1'b0;
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1;
    cyc();
    btns[b] = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    checks++; if (screen !== 2'd0) begin failures++; $display("FAIL reset_screen got=%0d exp=0", screen); end
    checks++; if (sel_idx !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_idx); end
    checks++; if (hilite_on !== 1'b1) begin failures++; $display("FAIL reset_hilite got=%0b exp=1", hilite_on); end
    checks++; if (note_req !== 1'b0) begin failures++; $display("FAIL reset_note_req got=%0b exp=0", note_req); end
    checks++; if (note_idx !== 3'd0) begin failures++; $display("FAIL reset_note_idx got=%0d exp=0", note_idx); end
    reset = 1'b1;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_menu_wrap();
    logic [2:0] exp_r[3] = '{3'd1, 3'd2, 3'd0};
    for (int i = 0; i < 3; i++) begin
      press(1); tick();
      checks++; if (sel_idx !== exp_r[i]) begin failures++; $display("FAIL menu_r%0d got=%0d exp=%0d", i, sel_idx, exp_r[i]); end
    end
    press(0); tick();
    checks++; if (sel_idx !== 3'd2) begin failures++; $display("FAIL menu_l_wrap got=%0d exp=2", sel_idx); end
    press(1); tick();
    checks++; if (sel_idx !== 3'd0 || screen !== 2'd0) begin failures++; $display("FAIL menu_r_wrap got=%0d/%0d exp=0/0", screen, sel_idx); end
    $display("test_menu_wrap done sel=%0d", sel_idx);
  endtask

  task automatic test_same_cycle_edge();
    btns[1] = 1'b1;
    refr_tick = 1'b1;
    cyc();
    btns[1] = 1'b0;
    refr_tick = 1'b0;
    checks++; if (sel_idx !== 3'd1) begin failures++; $display("FAIL same_cycle_edge got=%0d exp=1", sel_idx); end
    tick();
    checks++; if (sel_idx !== 3'd1) begin failures++; $display("FAIL edge_consumed got=%0d exp=1", sel_idx); end
    press(0); tick();
    $display("test_same_cycle_edge done sel=%0d", sel_idx);
  endtask

  task automatic test_priority();
    press(0); press(2);
    checks++; if (screen !== 2'd0 || sel_idx !== 3'd0) begin failures++; $display("FAIL midframe_hold got=%0d/%0d exp=0/0", screen, sel_idx); end
    tick();
    checks++; if (screen !== 2'd1 || sel_idx !== 3'd0) begin failures++; $display("FAIL sel_over_l got=%0d/%0d exp=1/0", screen, sel_idx); end
    tick();
    checks++; if (sel_idx !== 3'd0) begin failures++; $display("FAIL l_discarded got=%0d exp=0", sel_idx); end
    press(1); press(3); tick();
    checks++; if (screen !== 2'd0 || sel_idx !== 3'd0) begin failures++; $display("FAIL back_over_r got=%0d/%0d exp=0/0", screen, sel_idx); end
    press(2); tick();
    $display("test_priority done screen=%0d", screen);
  endtask

  task automatic test_play();
    for (int i = 0; i < 7; i++) begin press(1); tick(); end
    checks++; if (sel_idx !== 3'd7) begin failures++; $display("FAIL play_r7 got=%0d exp=7", sel_idx); end
    press(2); tick();
    checks++; if (note_req !== 1'b1 || note_idx !== 3'd7) begin failures++; $display("FAIL play_note got=%0b/%0d exp=1/7", note_req, note_idx); end
    checks++; if (screen !== 2'd1) begin failures++; $display("FAIL play_stay got=%0d exp=1", screen); end
    cyc();
    checks++; if (note_req !== 1'b0 || note_idx !== 3'd7) begin failures++; $display("FAIL play_note_one got=%0b/%0d exp=0/7", note_req, note_idx); end
    press(1); tick();
    checks++; if (sel_idx !== 3'd0) begin failures++; $display("FAIL play_wrap_r got=%0d exp=0", sel_idx); end
    press(0); tick();
    checks++; if (sel_idx !== 3'd7) begin failures++; $display("FAIL play_wrap_l got=%0d exp=7", sel_idx); end
    press(3); tick();
    checks++; if (screen !== 2'd0 || sel_idx !== 3'd0) begin failures++; $display("FAIL play_back got=%0d/%0d exp=0/0", screen, sel_idx); end
    $display("test_play done note_idx=%0d", note_idx);
  endtask

  task automatic test_listen();
    press(1); tick(); press(2); tick();
    checks++; if (screen !== 2'd2 || sel_idx !== 3'd0 || hilite_on !== 1'b0) begin failures++; $display("FAIL listen_enter got=%0d/%0d/%0b exp=2/0/0", screen, sel_idx, hilite_on); end
    for (int b = 0; b < 3; b++) begin
      press(b); tick();
      checks++; if (screen !== 2'd2 || sel_idx !== 3'd0 || note_req !== 1'b0) begin failures++; $display("FAIL listen_ignore%0d got=%0d/%0d/%0b exp=2/0/0", b, screen, sel_idx, note_req); end
    end
    press(3); tick();
    checks++; if (screen !== 2'd0 || sel_idx !== 3'd1 || hilite_on !== 1'b1) begin failures++; $display("FAIL listen_back got=%0d/%0d/%0b exp=0/1/1", screen, sel_idx, hilite_on); end
    press(3); tick();
    checks++; if (screen !== 2'd0 || sel_idx !== 3'd1) begin failures++; $display("FAIL menu_back_ignored got=%0d/%0d exp=0/1", screen, sel_idx); end
    $display("test_listen done");
  endtask

  task automatic test_reset_mid_frame();
    press(2); tick(); press(1); tick();
    press(2);
    reset = 1'b0;
    #1;
    checks++; if (screen !== 2'd0 || sel_idx !== 3'd0) begin failures++; $display("FAIL async_reset got=%0d/%0d exp=0/0", screen, sel_idx); end
    cyc();
    reset = 1'b1;
    cyc();
    tick();
    checks++; if (note_req !== 1'b0 || screen !== 2'd0 || sel_idx !== 3'd0) begin failures++; $display("FAIL reset_discard got=%0b/%0d/%0d exp=0/0/0", note_req, screen, sel_idx); end
    cyc();
    checks++; if (note_req !== 1'b0) begin failures++; $display("FAIL reset_no_note got=%0b exp=0", note_req); end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_held_through_reset();
    btns[1] = 1'b1;
    do_reset();
    tick();
    checks++; if (sel_idx !== 3'd0) begin failures++; $display("FAIL held_no_edge got=%0d exp=0", sel_idx); end
    btns[1] = 1'b0;
    cyc();
    press(1); tick();
    checks++; if (sel_idx !== 3'd1) begin failures++; $display("FAIL held_then_press got=%0d exp=1", sel_idx); end
    $display("test_held_through_reset done");
  endtask

`ifdef HILITE_BLINK_EN
  task automatic test_blink();
    logic exp_h[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (hilite_on !== exp_h[i]) begin failures++; $display("FAIL blink_t%0d got=%0b exp=%0b", i, hilite_on, exp_h[i]); end
    end
    tick();
    checks++; if (hilite_on !== 1'b0) begin failures++; $display("FAIL blink_low got=%0b exp=0", hilite_on); end
    press(1); tick();
    checks++; if (hilite_on !== 1'b1 || sel_idx !== 3'd1) begin failures++; $display("FAIL blink_force got=%0b/%0d exp=1/1", hilite_on, sel_idx); end
    tick();
    checks++; if (hilite_on !== 1'b1) begin failures++; $display("FAIL blink_cnt_clr got=%0b exp=1", hilite_on); end
    tick();
    checks++; if (hilite_on !== 1'b0) begin failures++; $display("FAIL blink_resume got=%0b exp=0", hilite_on); end
    $display("test_blink done");
  endtask
`endif

  initial begin
    test_reset();
    test_menu_wrap();
    test_same_cycle_edge();
    test_priority();
    test_play();
    test_listen();
    test_reset_mid_frame();
    test_held_through_reset();
`ifdef HILITE_BLINK_EN
    test_blink();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
